// File: rtl/dmem_lsu_pkg.sv
// Shared constants, request payload and helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

    localparam int unsigned LSU_XLEN = 32;

    // DataMem function codes
    localparam logic [1:0] MF_RD = 2'd0;
    localparam logic [1:0] MF_WR = 2'd1;

    // Request function
    localparam logic FCN_LD = 1'b0;
    localparam logic FCN_ST = 1'b1;

    // Access type codes; unlisted codes behave as a word
    localparam logic [2:0] MT_B  = 3'd0;
    localparam logic [2:0] MT_H  = 3'd1;
    localparam logic [2:0] MT_W  = 3'd2;
    localparam logic [2:0] MT_BU = 3'd4;
    localparam logic [2:0] MT_HU = 3'd5;

    // LSU states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    // Latched request payload; lane is the effective byte offset within the word
    typedef struct packed {
        logic [LSU_XLEN-1:0] wdata;
        logic                fcn;
        logic [2:0]          typ;
        logic [1:0]          lane;
    } lsu_req_t;

    function automatic logic is_byte(input logic [2:0] typ);
        return (typ == MT_B) || (typ == MT_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] typ);
        return (typ == MT_H) || (typ == MT_HU);
    endfunction

    function automatic logic is_word(input logic [2:0] typ);
        return !is_byte(typ) && !is_half(typ);
    endfunction

    // Byte offset actually used: halves ignore bit 0, words always use lane 0
    function automatic logic [1:0] eff_lane(input logic [2:0] typ, input logic [1:0] lo);
        if (is_word(typ)) begin
            return 2'b00;
        end else if (is_half(typ)) begin
            return {lo[1], 1'b0};
        end
        return lo;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane extraction/extension for loads and lane merge for sub-word stores.
module dmem_lane_align
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rd_word,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      typ,
    input  logic [1:0]      lane,
    output logic [XLEN-1:0] load_data_c,
    output logic [XLEN-1:0] store_word_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half out of the read word
    always_comb begin
        case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Sign/zero extension of the selected lane
    always_comb begin
        case (typ)
            MT_B:    load_data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            MT_BU:   load_data_c = {{(XLEN-8){1'b0}}, byte_sel};
            MT_H:    load_data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
            MT_HU:   load_data_c = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data_c = rd_word;
        endcase
    end

    // Replace only the addressed lane; a word store takes the new data whole
    always_comb begin
        store_word_c = rd_word;
        if (is_byte(typ)) begin
            case (lane)
                2'd0:    store_word_c[7:0]   = wdata[7:0];
                2'd1:    store_word_c[15:8]  = wdata[7:0];
                2'd2:    store_word_c[23:16] = wdata[7:0];
                default: store_word_c[31:24] = wdata[7:0];
            endcase
        end else if (is_half(typ)) begin
            if (lane[1]) begin
                store_word_c[31:16] = wdata[15:0];
            end else begin
                store_word_c[15:0] = wdata[15:0];
            end
        end else begin
            store_word_c = wdata;
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the word-wide DataMem: alignment, sub-word RMW, load extension.
// Optional build macro DMEM_LSU_MISALIGN_TRAP_EN: misaligned H/HU/W requests skip DataMem
// and respond with io_resp_xcpt = 1; otherwise the offending low address bits are ignored.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned XLEN       = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            io_req_valid,
    output logic            io_req_ready,
    input  logic [XLEN-1:0] io_req_addr,
    input  logic [XLEN-1:0] io_req_wdata,
    input  logic            io_req_fcn,
    input  logic [2:0]      io_req_typ,
    output logic            io_resp_valid,
    input  logic            io_resp_ready,
    output logic [XLEN-1:0] io_resp_rdata,
    output logic            io_resp_xcpt,
    output logic [XLEN-1:0] io_mem_addr,
    output logic [XLEN-1:0] io_mem_wr_data,
    output logic [1:0]      io_mem_func,
    output logic            io_mem_en,
    input  logic [XLEN-1:0] io_mem_rd_data
);

    localparam int unsigned CNT_W = 2;

    logic [2:0]       state_q, state_d;
    lsu_req_t         req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;
    logic             resp_xcpt_q, resp_xcpt_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]  mem_wr_data_q, mem_wr_data_d;
    logic [1:0]       mem_func_q, mem_func_d;
    logic             mem_en_q, mem_en_d;
    logic             trap_c;
    logic [XLEN-1:0]  load_data_c;
    logic [XLEN-1:0]  store_word_c;

    // Misaligned-access detection on the incoming request
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    assign trap_c = (is_half(io_req_typ) && io_req_addr[0]) ||
                    (is_word(io_req_typ) && (io_req_addr[1:0] != 2'b00));
`else
    assign trap_c = 1'b0;
`endif

    dmem_lane_align #(.XLEN(XLEN)) u_align (
        .rd_word      (io_mem_rd_data),
        .wdata        (req_q.wdata),
        .typ          (req_q.typ),
        .lane         (req_q.lane),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    // Next-state and next-output logic; every output is registered from here
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        cnt_d         = cnt_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_xcpt_d   = resp_xcpt_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_func_d    = mem_func_q;
        mem_en_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (io_req_valid && req_ready_q) begin
                    req_d.wdata = io_req_wdata;
                    req_d.fcn   = io_req_fcn;
                    req_d.typ   = io_req_typ;
                    req_d.lane  = eff_lane(io_req_typ, io_req_addr[1:0]);
                    req_ready_d = 1'b0;
                    mem_addr_d  = {io_req_addr[XLEN-1:2], 2'b00};
                    cnt_d       = '0;
                    if (trap_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_xcpt_d  = 1'b1;
                    end else if ((io_req_fcn == FCN_ST) && is_word(io_req_typ)) begin
                        state_d       = ST_WR;
                        mem_en_d      = 1'b1;
                        mem_func_d    = MF_WR;
                        mem_wr_data_d = io_req_wdata;
                    end else begin
                        state_d    = ST_RD;
                        mem_en_d   = 1'b1;
                        mem_func_d = MF_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
                    if (req_q.fcn == FCN_LD) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_data_c;
                        resp_xcpt_d  = 1'b0;
                    end else begin
                        state_d       = ST_WR;
                        mem_en_d      = 1'b1;
                        mem_func_d    = MF_WR;
                        mem_wr_data_d = store_word_c;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
                resp_xcpt_d  = 1'b0;
            end
            ST_RESP: begin
                if (io_resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_xcpt_d  = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_xcpt_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_func_q    <= MF_RD;
            mem_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_xcpt_q   <= resp_xcpt_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_func_q    <= mem_func_d;
            mem_en_q      <= mem_en_d;
        end
    end

    assign io_req_ready   = req_ready_q;
    assign io_resp_valid  = resp_valid_q;
    assign io_resp_rdata  = resp_rdata_q;
    assign io_resp_xcpt   = resp_xcpt_q;
    assign io_mem_addr    = mem_addr_q;
    assign io_mem_wr_data = mem_wr_data_q;
    assign io_mem_func    = mem_func_q;
    assign io_mem_en      = mem_en_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed latency/lane cases, stall, mid-op reset, random traffic.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int unsigned L = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_fcn = 1'b0;
    logic [2:0]  req_typ = '0;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_xcpt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic [1:0]  mem_func;
    logic        mem_en;

    typedef struct {
        logic [31:0] rdata;
        logic        xcpt;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  func;
        logic [31:0] addr;
        logic [31:0] data;
    } mev_t;

    exp_t        exp_q[$];
    mev_t        mev_q[$];
    int          resp_cyc_q[$];
    exp_t        mon_e;
    logic [31:0] dmem[256];
    logic [31:0] ref_mem[256];
    logic [31:0] rd_pipe[L];
    bit          bd_we = 1'b0;
    int          bd_idx = 0;
    logic [31:0] bd_data = '0;
    bit          hold_ready = 1'b0;
    bit          rnd_mode = 1'b0;
    bit          rnd_bit = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = '0;
    logic        last_xcpt = 1'b0;

    assign resp_ready  = hold_ready ? 1'b0 : (rnd_mode ? rnd_bit : 1'b1);
    assign mem_rd_data = rd_pipe[L-1];

    dmem_lsu #(.RD_LATENCY(L), .XLEN(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .io_req_valid   (req_valid),
        .io_req_ready   (req_ready),
        .io_req_addr    (req_addr),
        .io_req_wdata   (req_wdata),
        .io_req_fcn     (req_fcn),
        .io_req_typ     (req_typ),
        .io_resp_valid  (resp_valid),
        .io_resp_ready  (resp_ready),
        .io_resp_rdata  (resp_rdata),
        .io_resp_xcpt   (resp_xcpt),
        .io_mem_addr    (mem_addr),
        .io_mem_wr_data (mem_wr_data),
        .io_mem_func    (mem_func),
        .io_mem_en      (mem_en),
        .io_mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 rnd_bit = ($urandom_range(0, 3) != 0);
    end

    // DataMem model: read data appears L cycles after the read strobe
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (mem_en && mem_func == MF_RD) ? dmem[mem_addr[9:2]] : 32'hBAD0BAD0;
        if (mem_en && mem_func == MF_WR) dmem[mem_addr[9:2]] = mem_wr_data;
        if (bd_we) dmem[bd_idx] = bd_data;
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, expv);
        end
    endfunction

    // Reference: byte-granular view of memory, computed from access size and offset
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                   input logic f, input logic [2:0] ty);
        exp_t r;
        int size;
        int off;
        int w;
        logic [31:0] mask;
        logic [31:0] v;
        r.rdata = '0;
        r.xcpt  = 1'b0;
        w    = int'(a[9:2]);
        size = (ty == MT_B || ty == MT_BU) ? 1 : (ty == MT_H || ty == MT_HU) ? 2 : 4;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        if ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00)) begin
            r.xcpt = 1'b1;
            return r;
        end
`endif
        off  = (size == 1) ? int'(a[1:0]) : (size == 2) ? 2 * int'(a[1]) : 0;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        if (f == FCN_LD) begin
            v = (ref_mem[w] >> (8 * off)) & mask;
            if ((ty == MT_B || ty == MT_H) && v[8*size-1]) v = v | ~mask;
            r.rdata = v;
        end else begin
            ref_mem[w] = (ref_mem[w] & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
        end
        return r;
    endfunction

    // Monitor: DataMem strobe log and response scoreboard
    always @(negedge clk) begin
        if (mem_en) mev_q.push_back('{cyc, mem_func, mem_addr, mem_wr_data});
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata %08h expected no response", resp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_xcpt", 32'(resp_xcpt), 32'(mon_e.xcpt));
                last_rdata = resp_rdata;
                last_xcpt  = resp_xcpt;
                resp_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic poke(input int idx, input logic [31:0] v);
        @(negedge clk);
        bd_idx  = idx;
        bd_data = v;
        bd_we   = 1'b1;
        ref_mem[idx] = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic f,
                         input logic [2:0] ty, input bit push, output int t);
        int g;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept: got req_ready 0 expected 1 within 200 cycles");
            t = -1;
            return;
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_fcn   = f;
        req_typ   = ty;
        t = cyc;
        if (push) exp_q.push_back(model(a, d, f, ty));
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_rst(input string p);
        chk({p, "_req_ready"},  32'(req_ready),  32'd1);
        chk({p, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({p, "_resp_rdata"}, resp_rdata,      32'd0);
        chk({p, "_resp_xcpt"},  32'(resp_xcpt),  32'd0);
        chk({p, "_mem_en"},     32'(mem_en),     32'd0);
        chk({p, "_mem_addr"},   mem_addr,        32'd0);
        chk({p, "_mem_wr"},     mem_wr_data,     32'd0);
        chk({p, "_mem_func"},   32'(mem_func),   32'd0);
    endtask

    function automatic int first_cyc();
        return (resp_cyc_q.size() > 0) ? resp_cyc_q[0] : -1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #1 reset_n = 1'b0;
        for (int i = 0; i < 256; i++) poke(i, $urandom);
        @(negedge clk);
        chk_rst("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Word store then word load
        mev_q.delete(); resp_cyc_q.delete();
        issue(32'h100, 32'hDEADBEEF, FCN_ST, MT_W, 1'b1, t);
        drain();
        chk("sw_nev", 32'(mev_q.size()), 32'd1);
        if (mev_q.size() > 0) begin
            chk("sw_wr_cyc", 32'(mev_q[0].cyc), 32'(t + 1));
            chk("sw_func", 32'(mev_q[0].func), 32'(MF_WR));
            chk("sw_addr", mev_q[0].addr, 32'h100);
            chk("sw_data", mev_q[0].data, 32'hDEADBEEF);
        end
        chk("sw_resp_cyc", 32'(first_cyc()), 32'(t + 2));

        mev_q.delete(); resp_cyc_q.delete();
        issue(32'h100, 32'h0, FCN_LD, MT_W, 1'b1, t);
        drain();
        chk("lw_nev", 32'(mev_q.size()), 32'd1);
        if (mev_q.size() > 0) begin
            chk("lw_rd_cyc", 32'(mev_q[0].cyc), 32'(t + 1));
            chk("lw_func", 32'(mev_q[0].func), 32'(MF_RD));
        end
        chk("lw_resp_cyc", 32'(first_cyc()), 32'(t + 2 + L));
        chk("lw_data", last_rdata, 32'hDEADBEEF);

        // Sub-word loads
        poke(32, 32'h12345680);
        issue(32'h80, 32'h0, FCN_LD, MT_B, 1'b1, t);  drain();
        chk("lb_data", last_rdata, 32'hFFFFFF80);
        issue(32'h80, 32'h0, FCN_LD, MT_BU, 1'b1, t); drain();
        chk("lbu_data", last_rdata, 32'h00000080);
        issue(32'h82, 32'h0, FCN_LD, MT_H, 1'b1, t);  drain();
        chk("lh_data", last_rdata, 32'h00001234);

        // Sub-word stores (read-modify-write)
        poke(16, 32'hAABBCCDD);
        mev_q.delete(); resp_cyc_q.delete();
        issue(32'h41, 32'h77, FCN_ST, MT_B, 1'b1, t);
        drain();
        chk("sb_nev", 32'(mev_q.size()), 32'd2);
        if (mev_q.size() > 1) begin
            chk("sb_rd_cyc", 32'(mev_q[0].cyc), 32'(t + 1));
            chk("sb_wr_cyc", 32'(mev_q[1].cyc), 32'(t + 2 + L));
            chk("sb_wr_data", mev_q[1].data, 32'hAABB77DD);
        end
        chk("sb_resp_cyc", 32'(first_cyc()), 32'(t + 3 + L));
        poke(16, 32'hAABBCCDD);
        mev_q.delete();
        issue(32'h42, 32'h1122, FCN_ST, MT_H, 1'b1, t);
        drain();
        if (mev_q.size() > 1) chk("sh_wr_data", mev_q[1].data, 32'h1122CCDD);
        else chk("sh_nev", 32'(mev_q.size()), 32'd2);

        // Response stall
        poke(128, 32'hCAFEF00D);
        hold_ready = 1'b1;
        issue(32'h200, 32'h0, FCN_LD, MT_W, 1'b1, t);
        while (cyc < t + 2 + int'(L)) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_rdata", resp_rdata, 32'hCAFEF00D);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_mem_en", 32'(mem_en), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 hold_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_idle_ready", 32'(req_ready), 32'd1);
        drain();

        // Reset during WAIT of a byte store
        poke(16, 32'hAABBCCDD);
        mev_q.delete();
        issue(32'h41, 32'h55, FCN_ST, MT_B, 1'b0, t);
        while (cyc < t + 2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 chk_rst("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_nev", 32'(mev_q.size()), 32'd1);
        if (mev_q.size() > 0) chk("midrst_func", 32'(mev_q[0].func), 32'(MF_RD));
        chk("midrst_mem", dmem[16], 32'hAABBCCDD);

        // Misaligned word load
        mev_q.delete(); resp_cyc_q.delete();
        issue(32'h102, 32'h0, FCN_LD, MT_W, 1'b1, t);
        drain();
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        chk("mis_nev", 32'(mev_q.size()), 32'd0);
        chk("mis_resp_cyc", 32'(first_cyc()), 32'(t + 1));
        chk("mis_xcpt", 32'(last_xcpt), 32'd1);
`else
        chk("mis_nev", 32'(mev_q.size()), 32'd1);
        if (mev_q.size() > 0) chk("mis_addr", mev_q[0].addr, 32'h100);
        chk("mis_xcpt", 32'(last_xcpt), 32'd0);
        chk("mis_data", last_rdata, 32'hDEADBEEF);
`endif

        // Random traffic with random response back-pressure
        rnd_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            issue(32'($urandom_range(0, 1023)), $urandom, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'b1, t);
        end
        drain();
        rnd_mode = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 256; i++) chk("mem_word", dmem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
